// File: rtl/synthesijer_fconv_result_buf_if.sv
// Signal bundle between the request/converter/consumer side and the result buffer.
// Handshake: a beat moves on any cycle where valid and ready are both high; valid does not wait on ready.
interface synthesijer_fconv_result_buf_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             req_nd;
    logic             req_ready;
    logic             cv_nd;
    logic             cv_valid;
    logic [WIDTH-1:0] cv_result;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic [CW-1:0]    inflight;
    logic [1:0]       err;

    modport slave (
        input  req_nd, cv_valid, cv_result, out_ready,
        output req_ready, cv_nd, out_data, out_valid, count, inflight, err
    );

    modport master (
        output req_nd, cv_valid, cv_result, out_ready,
        input  req_ready, cv_nd, out_data, out_valid, count, inflight, err
    );
endinterface

// File: rtl/synthesijer_fconv_result_buf.sv
// Credit-gated issue to a fixed-latency converter with a first-word-fall-through result FIFO.
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module synthesijer_fconv_result_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    synthesijer_fconv_result_buf_if.slave    bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int CW1 = CW + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [CW:0]   CREDITS = CW1'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_inflight;
    logic [1:0]       r_err;

    logic             w_req_ready;
    logic             w_cv_nd;
    logic             w_full;
    logic             w_pop;
    logic             w_write;
    logic             w_inc;
    logic             w_dec;
    logic [CW:0]      w_used;

    // Every issued conversion reserves a slot, so the converter never needs backpressure.
    always_comb begin
        w_used      = {1'b0, r_count} + {1'b0, r_inflight};
        w_req_ready = reset && (w_used < CREDITS);
        w_cv_nd     = bus.req_nd && w_req_ready;
        w_full      = (r_count == FULL);
        w_pop       = (r_count != '0) && bus.out_ready;
        w_write     = reset && bus.cv_valid && (!w_full || w_pop);
        w_inc       = w_cv_nd && !bus.cv_valid;
        w_dec       = bus.cv_valid && !w_cv_nd && (r_inflight != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_err      <= '0;
        end else begin
            if (w_write) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);

            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_inc)      r_inflight <= r_inflight + CW'(1);
            else if (w_dec) r_inflight <= r_inflight - CW'(1);

            // Sticky until reset: dropped word, and a result nobody asked for.
            if (bus.cv_valid && w_full && !w_pop)  r_err[0] <= 1'b1;
            if (bus.cv_valid && r_inflight == '0)  r_err[1] <= 1'b1;
        end
    end

    // Storage needs no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_wr_ptr] <= bus.cv_result;
    end

    assign bus.req_ready = w_req_ready;
    assign bus.cv_nd     = w_cv_nd;
    assign bus.out_valid = (r_count != '0);
    assign bus.out_data  = r_mem[r_rd_ptr];
    assign bus.count     = r_count;
    assign bus.inflight  = r_inflight;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_synthesijer_fconv_result_buf.sv
// Bench for synthesijer_fconv_result_buf: vector table plus hand sequences, checked against a queue model.
module tb_synthesijer_fconv_result_buf;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;

    synthesijer_fconv_result_buf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    synthesijer_fconv_result_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          nd;
        bit          cvv;
        logic [31:0] cvr;
        bit          ordy;
        int          e_count;
        int          e_inflight;
        bit          e_ov;
        logic [31:0] e_data;
    } vec_t;

    vec_t        vecs [12];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q [$];
    int          m_count;
    int          m_inflight;
    logic [1:0]  m_err;
    bit          last_cv_nd;
    int          rx_count;
    bit          pipe [3];
    int          next_word;
    int          nd_pulses;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_count = 0;
        m_inflight = 0;
        m_err = 2'b00;
        exp_q.delete();
        pipe[0] = 1'b0; pipe[1] = 1'b0; pipe[2] = 1'b0;
    endtask

    // Drive one cycle of inputs, check the pre-edge view, advance the model, check the post-edge state.
    task automatic step(input bit nd, input bit cvv, input logic [31:0] cvr, input bit ordy);
        bit exp_rr, pop, wr, inc;
        bus.req_nd = nd;
        bus.cv_valid = cvv;
        bus.cv_result = cvr;
        bus.out_ready = ordy;
        #1;
        exp_rr = (m_count + m_inflight) < DEPTH;
        check("req_ready", 32'(bus.req_ready), 32'(exp_rr));
        check("cv_nd", 32'(bus.cv_nd), 32'(nd && exp_rr));
        check("out_valid", 32'(bus.out_valid), 32'(m_count != 0));
        last_cv_nd = bus.cv_nd;
        pop = (m_count != 0) && ordy;
        if (pop) begin
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_underflow: got pop with 0x%08h expected no data", bus.out_data);
            end else begin
                check("out_data", bus.out_data, exp_q.pop_front());
                rx_count++;
            end
        end
        wr = cvv && (m_count < DEPTH || pop);
        if (wr) exp_q.push_back(cvr);
        if (cvv && m_inflight == 0) m_err[1] = 1'b1;
        if (cvv && m_count == DEPTH && !pop) m_err[0] = 1'b1;
        inc = nd && exp_rr;
        if (inc && !cvv) m_inflight++;
        else if (cvv && !inc && m_inflight > 0) m_inflight--;
        m_count = m_count + int'(wr) - int'(pop);
        @(posedge clk);
        #1;
        check("count", 32'(bus.count), 32'(m_count));
        check("inflight", 32'(bus.inflight), 32'(m_inflight));
        check("err", 32'(bus.err), 32'(m_err));
    endtask

    // Latency-3 converter model fed by the observed cv_nd pulses.
    task automatic conv_cycle(input bit nd, input bit ordy);
        bit cvv;
        cvv = pipe[2];
        step(nd, cvv, cvv ? 32'(next_word) : 32'h0, ordy);
        if (cvv) next_word++;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = last_cv_nd;
        if (last_cv_nd) nd_pulses++;
    endtask

    initial begin
        vecs = '{
            '{1'b1, 1'b0, 32'h0,        1'b0, 0, 1, 1'b0, 32'h0},
            '{1'b0, 1'b0, 32'h0,        1'b0, 0, 1, 1'b0, 32'h0},
            '{1'b0, 1'b0, 32'h0,        1'b0, 0, 1, 1'b0, 32'h0},
            '{1'b0, 1'b1, 32'h3F800000, 1'b0, 1, 0, 1'b1, 32'h3F800000},
            '{1'b0, 1'b0, 32'h0,        1'b1, 0, 0, 1'b0, 32'h0},
            '{1'b1, 1'b0, 32'h0,        1'b0, 0, 1, 1'b0, 32'h0},
            '{1'b1, 1'b0, 32'h0,        1'b0, 0, 2, 1'b0, 32'h0},
            '{1'b1, 1'b1, 32'h11,       1'b0, 1, 2, 1'b1, 32'h11},
            '{1'b0, 1'b1, 32'h22,       1'b1, 1, 1, 1'b1, 32'h22},
            '{1'b0, 1'b1, 32'h33,       1'b0, 2, 0, 1'b1, 32'h22},
            '{1'b0, 1'b0, 32'h0,        1'b1, 1, 0, 1'b1, 32'h33},
            '{1'b0, 1'b0, 32'h0,        1'b1, 0, 0, 1'b0, 32'h0}
        };

        // Reset: everything quiet even with a request pending.
        bus.req_nd = 1'b1;
        bus.cv_valid = 1'b0;
        bus.cv_result = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", 32'(bus.count), 32'h0);
        check("rst_inflight", 32'(bus.inflight), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_cv_nd", 32'(bus.cv_nd), 32'h0);
        bus.req_nd = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("release_req_ready", 32'(bus.req_ready), 32'h1);
        model_clear();
        rx_count = 0;

        // Vector table: single result, then overlapping issue/return/pop.
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].nd, vecs[i].cvv, vecs[i].cvr, vecs[i].ordy);
            check($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].e_count));
            check($sformatf("vec%0d_inflight", i), 32'(bus.inflight), 32'(vecs[i].e_inflight));
            check($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov) check($sformatf("vec%0d_out_data", i), bus.out_data, vecs[i].e_data);
        end

        // Credit stall with no consumer.
        next_word = 32'h100;
        nd_pulses = 0;
        repeat (12) conv_cycle(1'b1, 1'b0);
        check("stall_pulses", 32'(nd_pulses), 32'd4);
        check("stall_req_ready", 32'(bus.req_ready), 32'h0);
        check("stall_count", 32'(bus.count), 32'd4);
        check("stall_inflight", 32'(bus.inflight), 32'h0);
        check("stall_err", 32'(bus.err), 32'h0);

        // Full buffer, pop and forced write in the same cycle.
        step(1'b0, 1'b1, 32'hAAAA0001, 1'b1);
        check("fullpw_count", 32'(bus.count), 32'd4);
        check("fullpw_err0", 32'(bus.err[0]), 32'h0);

        // Overflow: the dropped word must never surface.
        step(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        check("ovf_err0", 32'(bus.err[0]), 32'h1);
        check("ovf_count", 32'(bus.count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("ovf_no_deadbeef", 32'(bus.out_data == 32'hDEADBEEF), 32'h0);
            step(1'b0, 1'b0, 32'h0, 1'b1);
        end

        // Wrap-around stream with a random consumer.
        next_word = 1;
        nd_pulses = 0;
        rx_count = 0;
        for (int cyc = 0; cyc < 300 && rx_count < 10; cyc++)
            conv_cycle(nd_pulses < 10, 1'($urandom_range(0, 1)));
        check("wrap_rx_count", 32'(rx_count), 32'd10);
        check("wrap_words_sent", 32'(next_word), 32'd11);

        // Reset mid-stream discards everything; a late result is then unexpected.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h51, 1'b0);
        step(1'b0, 1'b1, 32'h52, 1'b0);
        check("pre_rst_count", 32'(bus.count), 32'd2);
        check("pre_rst_inflight", 32'(bus.inflight), 32'd1);
        bus.req_nd = 1'b1;
        bus.cv_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_count", 32'(bus.count), 32'h0);
        check("mid_rst_inflight", 32'(bus.inflight), 32'h0);
        check("mid_rst_err", 32'(bus.err), 32'h0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("mid_rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("mid_rst_cv_nd", 32'(bus.cv_nd), 32'h0);
        model_clear();
        bus.req_nd = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rel2_req_ready", 32'(bus.req_ready), 32'h1);
        step(1'b0, 1'b1, 32'h77, 1'b0);
        check("stray_err1", 32'(bus.err[1]), 32'h1);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
